// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: fetch / load-IR / decode / execute loop
// over N_UNITS execution units with a one-hot start/done handshake, EBREAK
// halt, illegal-selection and watchdog traps, single-step and counters.
module multicycle_sequencer #(
  parameter int unsigned ILEN         = 32,
  parameter int unsigned N_UNITS      = 3,
  parameter int unsigned CNT_W        = 64,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned EXEC_TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               step_mode,
  input  logic               step,
  input  logic [ILEN-1:0]    insn,
  input  logic               memory_done,
  output logic               memory_start,
  output logic               load_ins,
  input  logic [N_UNITS-1:0] unit_sel,
  output logic [N_UNITS-1:0] unit_start,
  input  logic [N_UNITS-1:0] unit_done,
  output logic               busy,
  output logic               halted,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic [2:0]         state_dbg,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [CNT_W-1:0]   instret_count
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StFetch    = 3'd1;
  localparam logic [2:0] StLoadIr   = 3'd2;
  localparam logic [2:0] StDecode   = 3'd3;
  localparam logic [2:0] StExec     = 3'd4;
  localparam logic [2:0] StStepWait = 3'd5;
  localparam logic [2:0] StHalt     = 3'd6;
  localparam logic [2:0] StTrap     = 3'd7;

  localparam logic [ILEN-1:0] Ebreak = ILEN'(32'h0010_0073);

  // Watchdog fires in the cycle where the count of cycles spent reaches the limit.
  localparam bit          MemTmoEn  = (MEM_TIMEOUT != 0);
  localparam bit          ExecTmoEn = (EXEC_TIMEOUT != 0);
  localparam logic [15:0] MemLimit  = 16'(MEM_TIMEOUT - 1);
  localparam logic [15:0] ExecLimit = 16'(EXEC_TIMEOUT - 1);

  logic [2:0]         state_q, state_d;
  logic [N_UNITS-1:0] sel_q, sel_d;
  logic [15:0]        tmo_q, tmo_d;
  logic [1:0]         cause_q, cause_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic               sel_onehot;
  logic               cyc_inc;

  assign sel_onehot = (unit_sel != '0) && ((unit_sel & (unit_sel - N_UNITS'(1))) == '0);

  // Next-state, watchdog, trap cause and counter update.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cause_d   = cause_q;
    instret_d = instret_q;
    tmo_d     = '0;
    case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        if (memory_done) begin
          state_d = StLoadIr;
        end else if (MemTmoEn && (tmo_q == MemLimit)) begin
          state_d = StTrap;
          cause_d = 2'd1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      StLoadIr: state_d = StDecode;
      StDecode: begin
        if (insn == Ebreak) begin
          state_d = StHalt;
        end else if (!sel_onehot) begin
          state_d = StTrap;
          cause_d = 2'd2;
        end else begin
          sel_d   = unit_sel;
          state_d = StExec;
        end
      end
      StExec: begin
        if ((unit_done & sel_q) != '0) begin
          instret_d = instret_q + CNT_W'(1);
          state_d   = step_mode ? StStepWait : StFetch;
        end else if (ExecTmoEn && (tmo_q == ExecLimit)) begin
          state_d = StTrap;
          cause_d = 2'd3;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      StStepWait: begin
        if (step) state_d = StFetch;
      end
      default: begin
        // HALT and TRAP are sticky until restarted.
        if (start) begin
          state_d = StFetch;
          cause_d = 2'd0;
        end
      end
    endcase
    // The visible count includes the cycle currently being spent in an active state.
    cyc_inc = (state_d != StIdle) && (state_d != StHalt) && (state_d != StTrap);
    cycle_d = cycle_q + CNT_W'(cyc_inc);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      tmo_q     <= '0;
      cause_q   <= 2'd0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      tmo_q     <= tmo_d;
      cause_q   <= cause_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  // Moore outputs decoded from registered state.
  always_comb begin
    memory_start  = (state_q == StFetch);
    load_ins      = (state_q == StLoadIr);
    unit_start    = (state_q == StExec) ? sel_q : '0;
    busy          = (state_q == StFetch) || (state_q == StLoadIr) ||
                    (state_q == StDecode) || (state_q == StExec);
    halted        = (state_q == StHalt);
    trap          = (state_q == StTrap);
    trap_cause    = cause_q;
    state_dbg     = state_q;
    cycle_count   = cycle_q;
    instret_count = instret_q;
  end

endmodule
